// File: rtl/gelu_pkg.sv
// Shared widths, clamp limits, 2^f interpolation tables and stage records
// for the GELU exp2 stage and any other exponent path reusing the LUT.
package gelu_pkg;

    localparam int unsigned Q        = 26;
    localparam int unsigned W        = 32;
    localparam int unsigned OQ       = 20;
    localparam int          S_LO     = -16;
    localparam int          S_HI     = 10;
    localparam int unsigned SEG_BITS = 3;

    localparam int unsigned N_SEG    = 1 << SEG_BITS;
    localparam int unsigned DF_W     = Q - SEG_BITS;
    localparam int unsigned LUT_W    = OQ + 1;
    localparam int unsigned PROD_W   = LUT_W + DF_W;
    localparam int unsigned N_W      = W - Q;
    localparam int unsigned CNT_W    = 32;

    localparam int           S_LO_Q  = S_LO * (2 ** Q);
    localparam int           S_HI_Q  = S_HI * (2 ** Q);
    localparam logic [W-1:0] ONE_OQ  = W'(1) << OQ;

    // base[k] = 2^(k/8) in OQ
    localparam logic [LUT_W-1:0] BASE_LUT [N_SEG] = '{
        21'd1048576, 21'd1143480, 21'd1246974, 21'd1359835,
        21'd1482910, 21'd1617125, 21'd1763488, 21'd1923097
    };

    // slope[k] = 8*(2^((k+1)/8) - 2^(k/8)) in OQ, i.e. d(2^f)/df over segment k
    localparam logic [LUT_W-1:0] SLOPE_LUT [N_SEG] = '{
        21'd759232,  21'd827952,  21'd902888,  21'd984600,
        21'd1073720, 21'd1170904, 21'd1276872, 21'd1392440
    };

    typedef struct packed {
        logic           valid;
        logic [N_W-1:0] n;
        logic [Q-1:0]   f;
        logic [W-1:0]   x;
        logic           byp_lo;
        logic           byp_hi;
    } s1_rec_t;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] x;
        logic         byp_lo;
        logic         byp_hi;
    } sb_rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/gelu_exp2_lut.sv
// Combinational segment ROM for piecewise-linear 2^f, f in [0,1):
// k selects the segment, returns its base value and per-unit-f slope in OQ.
module gelu_exp2_lut
    import gelu_pkg::*;
(
    input  logic [SEG_BITS-1:0] i_k,
    output logic [LUT_W-1:0]    o_base,
    output logic [LUT_W-1:0]    o_slope
);

    assign o_base  = BASE_LUT[i_k];
    assign o_slope = SLOPE_LUT[i_k];

endmodule

// File: rtl/gelu_exp2_unit.sv
// Four-stage d = 1 + 2^s pipeline feeding the GELU divider, stall-all handshake.
// Optional saturation counters under `GELU_EXP2_STATS_EN.
module gelu_exp2_unit
    import gelu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     s_in,
    input  logic [W-1:0]     x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     d_out,
    output logic [W-1:0]     x_out,
    output logic             byp_lo,
    output logic             byp_hi
`ifdef GELU_EXP2_STATS_EN
    ,
    output logic [CNT_W-1:0] sat_lo_cnt,
    output logic [CNT_W-1:0] sat_hi_cnt
`endif
);

    logic                  w_en;
    logic                  w_accept;
    logic signed [W-1:0]   w_s;
    logic signed [W-1:0]   w_sc;
    logic                  w_lo;
    logic                  w_hi;
    s1_rec_t               w_s1_next;
    s1_rec_t               r_s1;

    logic [SEG_BITS-1:0]   w_k;
    logic [DF_W-1:0]       w_df;
    logic [LUT_W-1:0]      w_base;
    logic [LUT_W-1:0]      w_slope;
    logic [LUT_W-1:0]      w_p;
    sb_rec_t               w_s2_sb;
    sb_rec_t               r_s2_sb;
    logic [N_W-1:0]        r_s2_n;
    logic [LUT_W-1:0]      r_s2_base;
    logic [LUT_W-1:0]      r_s2_p;

    logic [LUT_W-1:0]      w_m;
    logic [W-1:0]          w_m_ext;
    logic                  w_neg;
    logic [N_W-1:0]        w_sh_amt;
    logic [W-1:0]          w_e;
    sb_rec_t               r_s3_sb;
    logic [W-1:0]          r_s3_e;

    logic [W-1:0]          w_d;
    logic                  r_out_valid;
    logic [W-1:0]          r_d_out;
    logic [W-1:0]          r_x_out;
    logic                  r_byp_lo;
    logic                  r_byp_hi;

    // Whole pipe advances together; bubbles are carried, not squeezed.
    assign w_en     = out_ready | ~r_out_valid;
    assign w_accept = in_valid & w_en;
    assign in_ready = w_en;

    // S1: clamp s and split into floor integer n and fraction f
    always_comb begin
        w_s  = $signed(s_in);
        w_lo = (w_s < S_LO_Q);
        w_hi = (w_s >= S_HI_Q);
        w_sc = w_s;
        if (w_lo) begin
            w_sc = W'(S_LO_Q);
        end else if (w_hi) begin
            w_sc = W'(S_HI_Q);
        end
        w_s1_next        = '0;
        w_s1_next.valid  = w_accept;
        w_s1_next.n      = w_sc[W-1:Q];
        w_s1_next.f      = w_sc[Q-1:0];
        w_s1_next.x      = x_in;
        w_s1_next.byp_lo = w_lo;
        w_s1_next.byp_hi = w_hi;
    end

    // S2: segment lookup and interpolation offset
    assign w_k  = r_s1.f[Q-1:DF_W];
    assign w_df = r_s1.f[DF_W-1:0];

    gelu_exp2_lut u_lut (
        .i_k     (w_k),
        .o_base  (w_base),
        .o_slope (w_slope)
    );

    // slope is per unit f while df counts f LSBs, hence the shift by the full Q
    assign w_p = LUT_W'((PROD_W'(w_slope) * PROD_W'(w_df)) >> Q);

    always_comb begin
        w_s2_sb        = '0;
        w_s2_sb.valid  = r_s1.valid;
        w_s2_sb.x      = r_s1.x;
        w_s2_sb.byp_lo = r_s1.byp_lo;
        w_s2_sb.byp_hi = r_s1.byp_hi;
    end

    // S3: mantissa in [1,2) scaled by 2^n, right shifts truncate
    always_comb begin
        w_m      = r_s2_base + r_s2_p;
        w_m_ext  = W'(w_m);
        w_neg    = r_s2_n[N_W-1];
        w_sh_amt = w_neg ? (N_W'(0) - r_s2_n) : r_s2_n;
        w_e      = w_neg ? (w_m_ext >> w_sh_amt) : (w_m_ext << w_sh_amt);
    end

    // S4: add the leading 1
    assign w_d = r_s3_e + ONE_OQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1        <= '0;
            r_s2_sb     <= '0;
            r_s2_n      <= '0;
            r_s2_base   <= '0;
            r_s2_p      <= '0;
            r_s3_sb     <= '0;
            r_s3_e      <= '0;
            r_out_valid <= 1'b0;
            r_d_out     <= '0;
            r_x_out     <= '0;
            r_byp_lo    <= 1'b0;
            r_byp_hi    <= 1'b0;
        end else if (w_en) begin
            r_s1        <= w_s1_next;
            r_s2_sb     <= w_s2_sb;
            r_s2_n      <= r_s1.n;
            r_s2_base   <= w_base;
            r_s2_p      <= w_p;
            r_s3_sb     <= r_s2_sb;
            r_s3_e      <= w_e;
            r_out_valid <= r_s3_sb.valid;
            r_d_out     <= w_d;
            r_x_out     <= r_s3_sb.x;
            r_byp_lo    <= r_s3_sb.byp_lo;
            r_byp_hi    <= r_s3_sb.byp_hi;
        end
    end

    assign out_valid = r_out_valid;
    assign d_out     = r_d_out;
    assign x_out     = r_x_out;
    assign byp_lo    = r_byp_lo;
    assign byp_hi    = r_byp_hi;

`ifdef GELU_EXP2_STATS_EN
    logic [CNT_W-1:0] r_sat_lo_cnt;
    logic [CNT_W-1:0] r_sat_hi_cnt;

    // Counted at acceptance so stalled or reset-dropped beats still register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_lo_cnt <= '0;
            r_sat_hi_cnt <= '0;
        end else if (w_accept) begin
            if (w_lo) begin
                r_sat_lo_cnt <= sat_inc(r_sat_lo_cnt);
            end
            if (w_hi) begin
                r_sat_hi_cnt <= sat_inc(r_sat_hi_cnt);
            end
        end
    end

    assign sat_lo_cnt = r_sat_lo_cnt;
    assign sat_hi_cnt = r_sat_hi_cnt;
`endif

endmodule

// File: tb/tb_gelu_exp2_unit.sv
// Directed bench for gelu_exp2_unit: single beats, clamp boundaries,
// back-to-back stream, mid-stream stall and reset with beats in flight.
module tb_gelu_exp2_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] s_in;
    logic [31:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d_out;
    logic [31:0] x_out;
    logic        byp_lo;
    logic        byp_hi;
`ifdef GELU_EXP2_STATS_EN
    logic [31:0] sat_lo_cnt;
    logic [31:0] sat_hi_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] s_vec [10];
    logic [31:0] x_vec [10];

    always #5 clk = ~clk;

    gelu_exp2_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s_in       (s_in),
        .x_in       (x_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d_out      (d_out),
        .x_out      (x_out),
        .byp_lo     (byp_lo),
        .byp_hi     (byp_hi)
`ifdef GELU_EXP2_STATS_EN
        ,
        .sat_lo_cnt (sat_lo_cnt),
        .sat_hi_cnt (sat_hi_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic check_tol(input string tag, input logic [31:0] obs, input real exp_d);
        real got;
        real rel;
        n_checks++;
        got = real'(obs) / 1048576.0;
        rel = (got - exp_d) / exp_d;
        if (rel < 0.0) rel = -rel;
        assert (rel <= 2.0e-3) else begin
            n_errors++;
            $error("FAIL %s: observed=%f expected=%f", tag, got, exp_d);
        end
    endtask

    // Reference: 1 + 2^s with s clamped to [-16, 10]
    function automatic real d_model(input logic [31:0] s);
        real sr;
        sr = real'($signed(s)) / 67108864.0;
        if (sr < -16.0) sr = -16.0;
        if (sr > 10.0) sr = 10.0;
        return 1.0 + $pow(2.0, sr);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat into an empty pipe; checks latency, d, x and flags.
    task automatic run_single(input string tag, input logic [31:0] s, input logic [31:0] x,
                              input bit exact, input logic [31:0] exp_d,
                              input bit exp_lo, input bit exp_hi);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        s_in      = s;
        x_in      = x;
        step();
        in_valid = 1'b0;
        s_in     = '0;
        x_in     = '0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        if (exact) check_eq({tag, "_d"}, d_out, exp_d);
        else       check_tol({tag, "_d"}, d_out, d_model(s));
        check_eq({tag, "_x"}, x_out, x);
        check_eq({tag, "_lo"}, 32'(byp_lo), 32'(exp_lo));
        check_eq({tag, "_hi"}, 32'(byp_hi), 32'(exp_hi));
        step();
    endtask

    // Ten polynomial outputs; optional 3-cycle out_ready drop at cycles 6..8.
    task automatic run_stream(input string tag, input bit with_stall);
        int  bi;
        int  oi;
        int  first;
        int  last;
        bit  stall;
        bi    = 0;
        oi    = 0;
        first = -1;
        last  = -1;
        for (int cyc = 0; cyc < 60 && oi < 10; cyc++) begin
            stall     = with_stall && (cyc >= 6) && (cyc <= 8);
            out_ready = !stall;
            in_valid  = (bi < 10);
            s_in      = (bi < 10) ? s_vec[bi] : 32'd0;
            x_in      = (bi < 10) ? x_vec[bi] : 32'd0;
            #1;
            check_eq({tag, "_in_ready"}, 32'(in_ready), 32'(out_ready));
            if (out_valid === 1'b1 && oi < 10) begin
                check_eq({tag, "_x"}, x_out, x_vec[oi]);
                check_tol({tag, "_d"}, d_out, d_model(s_vec[oi]));
                if (out_ready) begin
                    if (first < 0) first = cyc;
                    last = cyc;
                    oi++;
                end
            end
            @(posedge clk);
            #1;
            if (in_valid && out_ready) bi++;
        end
        in_valid = 1'b0;
        check_eq({tag, "_count"}, 32'(oi), 32'd10);
        check_eq({tag, "_span"}, 32'(last - first), with_stall ? 32'd12 : 32'd9);
    endtask

    initial begin
        int stale;

        for (int i = 0; i < 10; i++) begin
            real xr;
            real sr;
            xr = -2.0 + 0.5 * i;
            sr = -2.30220819814 * (xr + 0.044715 * xr * xr * xr);
            x_vec[i] = 32'($rtoi(xr * 67108864.0));
            s_vec[i] = 32'($rtoi(sr * 67108864.0));
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        s_in      = '0;
        x_in      = '0;
        repeat (3) step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_d_out", d_out, 32'd0);
        check_eq("rst_x_out", x_out, 32'd0);
        check_eq("rst_byp", {30'd0, byp_lo, byp_hi}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        run_single("s0",     32'h0000_0000, 32'h0123_4567, 1'b1, 32'h0020_0000, 1'b0, 1'b0);
        run_single("s1",     32'h0400_0000, 32'hF800_0000, 1'b1, 32'h0030_0000, 1'b0, 1'b0);
        run_single("sm1",    32'hFC00_0000, 32'h0800_0000, 1'b1, 32'h0018_0000, 1'b0, 1'b0);
        run_single("shalf",  32'h0200_0000, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        run_single("s10",    32'h2800_0000, 32'h1111_0000, 1'b1, 32'h4010_0000, 1'b0, 1'b1);
        run_single("s12",    32'h3000_0000, 32'h2222_0000, 1'b1, 32'h4010_0000, 1'b0, 1'b1);
        run_single("s10m",   32'h27FF_FFFF, 32'h3333_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        run_single("sm20",   32'hB000_0000, 32'hEEEE_0000, 1'b1, 32'h0010_0010, 1'b1, 1'b0);
        run_single("sm16",   32'hC000_0000, 32'hDDDD_0000, 1'b1, 32'h0010_0010, 1'b0, 1'b0);
        run_single("sm16m",  32'hBFFF_FFFF, 32'hCCCC_0000, 1'b1, 32'h0010_0010, 1'b1, 1'b0);

        run_stream("stream", 1'b0);
        repeat (2) step();
        run_stream("stall", 1'b1);
        repeat (2) step();

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            s_in     = 32'h0400_0000;
            x_in     = 32'(i + 7);
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_d_out", d_out, 32'd0);
        rst   = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        check_eq("midrst_no_stale", 32'(stale), 32'd0);

`ifdef GELU_EXP2_STATS_EN
        check_eq("cnt_lo_rst", sat_lo_cnt, 32'd0);
        check_eq("cnt_hi_rst", sat_hi_cnt, 32'd0);
        run_single("cnt_m20", 32'hB000_0000, 32'h0000_0042, 1'b1, 32'h0010_0010, 1'b1, 1'b0);
        check_eq("cnt_lo_one", sat_lo_cnt, 32'd1);
        check_eq("cnt_hi_zero", sat_hi_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
